// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared definitions for the matrix-multiply sequencer (matrix_op_ctrl) and its
// index counter (matrix_idx_cnt).
//   STATE_W      width of the operation state code
//   ST_IDLE..    3-bit state codes seen on the state output
//   DIM_MAX      largest supported matrix dimension
//   state_t      enumerated FSM state type carrying the ST_* codes
// -----------------------------------------------------------------------------
package matrix_pkg;

  localparam int STATE_W = 3;
  localparam int DIM_MAX = 8;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD  = 3'd1;
  localparam logic [STATE_W-1:0] ST_CLEAR = 3'd2;
  localparam logic [STATE_W-1:0] ST_MAC   = 3'd3;
  localparam logic [STATE_W-1:0] ST_WRITE = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = ST_IDLE,
    S_LOAD  = ST_LOAD,
    S_CLEAR = ST_CLEAR,
    S_MAC   = ST_MAC,
    S_WRITE = ST_WRITE,
    S_DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/matrix_idx_cnt.sv
// -----------------------------------------------------------------------------
// matrix_idx_cnt
// Row / column / inner-product index counters for the matrix sequencer.
// All three counters wrap explicitly at DIM-1 (not at 2^IDX_W-1).
// Ports:
//   clk, reset_n        clock and asynchronous active-low reset
//   clr                 zero all three indices (priority over increments)
//   k_inc               advance k, wrapping to 0 after DIM-1
//   col_inc             advance col; on col wrap, advance row (also wrapping)
//   row_idx/col_idx/k_idx  current indices
//   k_last/col_last/row_last  index currently equals DIM-1
// -----------------------------------------------------------------------------
module matrix_idx_cnt
  import matrix_pkg::*;
#(
  parameter int DIM   = 4,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             k_inc,
  input  logic             col_inc,
  output logic [IDX_W-1:0] row_idx,
  output logic [IDX_W-1:0] col_idx,
  output logic [IDX_W-1:0] k_idx,
  output logic             k_last,
  output logic             col_last,
  output logic             row_last
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIM - 1);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

  assign k_last   = (k_idx   == LAST);
  assign col_last = (col_idx == LAST);
  assign row_last = (row_idx == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_idx <= '0;
      col_idx <= '0;
      k_idx   <= '0;
    end else if (clr) begin
      row_idx <= '0;
      col_idx <= '0;
      k_idx   <= '0;
    end else begin
      if (k_inc) begin
        k_idx <= k_last ? '0 : k_idx + ONE;
      end
      if (col_inc) begin
        col_idx <= col_last ? '0 : col_idx + ONE;
        // Row only moves when the column wraps; after the final element it
        // wraps too, so DONE presents all indices at zero.
        if (col_last) begin
          row_idx <= row_last ? '0 : row_idx + ONE;
        end
      end
    end
  end

endmodule

// File: rtl/matrix_op_ctrl.sv
// -----------------------------------------------------------------------------
// matrix_op_ctrl
// Sequencer FSM for the matrix-multiply datapath computing C = A*B over
// DIM x DIM matrices. Per element of C: CLEAR (1 cycle), MAC (DIM cycles),
// WRITE (1 cycle). One op is LOAD + DIM*DIM*(DIM+2) cycles + DONE.
// All outputs are Moore, decoded from registered state / indices.
// Optional feature: define MATRIX_OP_CTRL_PERF_EN to add cycle_cnt[15:0], a
// saturating count of busy cycles of the last op (cleared on entering LOAD,
// frozen by opclear, held in IDLE).
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   opstart        start request, honoured in IDLE only
//   opclear        synchronous abort to IDLE, priority over opstart
//   state          current state code (see matrix_pkg)
//   row_idx, col_idx, k_idx   C row / C column / inner-product index
//   mac_clr, mac_en, wr_en    accumulator clear / accumulate / result write
//   busy, done     not-IDLE flag, one-cycle completion pulse
//   cycle_cnt      (MATRIX_OP_CTRL_PERF_EN only) busy-cycle counter
// -----------------------------------------------------------------------------
module matrix_op_ctrl
  import matrix_pkg::*;
#(
  parameter int DIM   = 4,
  parameter int IDX_W = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               opstart,
  input  logic               opclear,
  output logic [STATE_W-1:0] state,
  output logic [IDX_W-1:0]   row_idx,
  output logic [IDX_W-1:0]   col_idx,
  output logic [IDX_W-1:0]   k_idx,
  output logic               mac_clr,
  output logic               mac_en,
  output logic               wr_en,
  output logic               busy,
  output logic               done
`ifdef MATRIX_OP_CTRL_PERF_EN
  ,
  output logic [15:0]        cycle_cnt
`endif
);

  state_t state_q;
  state_t state_d;
  logic   k_last;
  logic   col_last;
  logic   row_last;
  logic   idx_clr;
  logic   k_inc;
  logic   col_inc;

  // Next-state logic; opclear overrides everything, illegal codes recover.
  always_comb begin
    state_d = state_q;
    if (opclear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (opstart) state_d = S_LOAD;
        S_LOAD:  state_d = S_CLEAR;
        S_CLEAR: state_d = S_MAC;
        S_MAC:   if (k_last) state_d = S_WRITE;
        S_WRITE: state_d = (row_last && col_last) ? S_DONE : S_CLEAR;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Indices are zeroed whenever the op ends (abort, illegal, DONE) and
  // while leaving LOAD so every op starts from (0,0,0).
  assign idx_clr = (state_d == S_IDLE) || (state_q == S_LOAD);
  assign k_inc   = (state_q == S_MAC);
  assign col_inc = (state_q == S_WRITE);

  matrix_idx_cnt #(
    .DIM   (DIM),
    .IDX_W (IDX_W)
  ) u_idx (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (idx_clr),
    .k_inc    (k_inc),
    .col_inc  (col_inc),
    .row_idx  (row_idx),
    .col_idx  (col_idx),
    .k_idx    (k_idx),
    .k_last   (k_last),
    .col_last (col_last),
    .row_last (row_last)
  );

  // Moore output decode.
  assign state   = state_q;
  assign mac_clr = (state_q == S_CLEAR);
  assign mac_en  = (state_q == S_MAC);
  assign wr_en   = (state_q == S_WRITE);
  assign done    = (state_q == S_DONE);
  assign busy    = (state_q != S_IDLE);

`ifdef MATRIX_OP_CTRL_PERF_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if ((state_q == S_IDLE) && (state_d == S_LOAD)) begin
      cnt_q <= '0;
    end else if (busy && !opclear && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign cycle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_matrix_op_ctrl.sv
// -----------------------------------------------------------------------------
// tb_matrix_op_ctrl
// Bench for matrix_op_ctrl: a DIM=4 instance (IDX_W=3, so wrap must happen at
// DIM-1 rather than at the counter's natural limit) and a DIM=2 instance.
// Expected behaviour comes from an arithmetic model: an op is described by
// the number of edges since it started, from which state and indices are
// computed with division / modulo.
// -----------------------------------------------------------------------------
module tb_matrix_op_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       start4 = 1'b0, clear4 = 1'b0, start2 = 1'b0, clear2 = 1'b0;
  logic [2:0] state4, row4, col4, k4, state2;
  logic [0:0] row2, col2, k2;
  logic       mac_clr4, mac_en4, wr_en4, busy4, done4;
  logic       mac_clr2, mac_en2, wr_en2, busy2, done2;
`ifdef MATRIX_OP_CTRL_PERF_EN
  logic [15:0] cnt4, cnt2;
`endif

  matrix_op_ctrl #(.DIM(4), .IDX_W(3)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .opstart(start4), .opclear(clear4),
    .state(state4), .row_idx(row4), .col_idx(col4), .k_idx(k4),
    .mac_clr(mac_clr4), .mac_en(mac_en4), .wr_en(wr_en4),
    .busy(busy4), .done(done4)
`ifdef MATRIX_OP_CTRL_PERF_EN
    , .cycle_cnt(cnt4)
`endif
  );

  matrix_op_ctrl #(.DIM(2), .IDX_W(1)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .opstart(start2), .opclear(clear2),
    .state(state2), .row_idx(row2), .col_idx(col2), .k_idx(k2),
    .mac_clr(mac_clr2), .mac_en(mac_en2), .wr_en(wr_en2),
    .busy(busy2), .done(done2)
`ifdef MATRIX_OP_CTRL_PERF_EN
    , .cycle_cnt(cnt2)
`endif
  );

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] row;
    logic [2:0] col;
    logic [2:0] k;
    logic       mclr;
    logic       men;
    logic       wr;
    logic       busy;
    logic       done;
  } obs_t;

  obs_t act4, act2;
  assign act4 = {state4, row4, col4, k4, mac_clr4, mac_en4, wr_en4, busy4, done4};
  assign act2 = {state2, 2'b00, row2, 2'b00, col2, 2'b00, k2,
                 mac_clr2, mac_en2, wr_en2, busy2, done2};

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected outputs n edges into an op (n=0 idle, n=1 LOAD).
  function automatic obs_t model(input int dim, input int n);
    obs_t o;
    int per, m, e, ph;
    o = '0;
    per = dim + 2;
    if (n == 0) return o;
    o.busy = 1'b1;
    if (n == 1) begin
      o.st = 3'd1;
      return o;
    end
    m = n - 2;
    if (m >= dim * dim * per) begin
      o.st = 3'd5;
      o.done = 1'b1;
      return o;
    end
    e = m / per;
    ph = m % per;
    o.row = 3'(e / dim);
    o.col = 3'(e % dim);
    if (ph == 0) begin
      o.st = 3'd2; o.mclr = 1'b1;
    end else if (ph <= dim) begin
      o.st = 3'd3; o.men = 1'b1; o.k = 3'(ph - 1);
    end else begin
      o.st = 3'd4; o.wr = 1'b1;
    end
    return o;
  endfunction

  function automatic int model_next(input int dim, input int n, input logic s, input logic c);
    if (n == 0) return (s && !c) ? 1 : 0;
    if (c) return 0;
    if (n >= 2 + dim * dim * (dim + 2)) return 0;
    return n + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic       s;
    logic       c;
    logic [2:0] st;
    logic [2:0] row;
    logic [2:0] col;
    logic [2:0] k;
  } vec_t;

  vec_t tbl[14];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int lat, nwr, ndone, macs, n4, n2, nn4, nn2;
    logic s4, c4, s2, c2;

    // Reset state
    #2;
    chk("reset_dut4", act4, 0);
    chk("reset_dut2", act2, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("idle_after_reset", {act4, act2}, 0);

    // Table-driven DIM=2 sequence
    tbl[0]  = '{1'b1, 1'b0, 3'd1, 3'd0, 3'd0, 3'd0};
    tbl[1]  = '{1'b0, 1'b0, 3'd2, 3'd0, 3'd0, 3'd0};
    tbl[2]  = '{1'b0, 1'b0, 3'd3, 3'd0, 3'd0, 3'd0};
    tbl[3]  = '{1'b0, 1'b0, 3'd3, 3'd0, 3'd0, 3'd1};
    tbl[4]  = '{1'b0, 1'b0, 3'd4, 3'd0, 3'd0, 3'd0};
    tbl[5]  = '{1'b1, 1'b0, 3'd2, 3'd0, 3'd1, 3'd0};
    tbl[6]  = '{1'b0, 1'b0, 3'd3, 3'd0, 3'd1, 3'd0};
    tbl[7]  = '{1'b0, 1'b0, 3'd3, 3'd0, 3'd1, 3'd1};
    tbl[8]  = '{1'b0, 1'b0, 3'd4, 3'd0, 3'd1, 3'd0};
    tbl[9]  = '{1'b0, 1'b0, 3'd2, 3'd1, 3'd0, 3'd0};
    tbl[10] = '{1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 3'd0};
    tbl[11] = '{1'b1, 1'b1, 3'd0, 3'd0, 3'd0, 3'd0};
    tbl[12] = '{1'b1, 1'b0, 3'd1, 3'd0, 3'd0, 3'd0};
    tbl[13] = '{1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 3'd0};
    for (int i = 0; i < 14; i++) begin
      start2 = tbl[i].s;
      clear2 = tbl[i].c;
      tick();
      chk($sformatf("tbl[%0d]", i), {act2.st, act2.row, act2.col, act2.k},
          {tbl[i].st, tbl[i].row, tbl[i].col, tbl[i].k});
    end
    start2 = 1'b0;
    clear2 = 1'b0;

    // Full DIM=4 op, then again with opstart re-pulsed while busy
    for (int pass = 0; pass < 2; pass++) begin
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      lat = -1; nwr = 0; ndone = 0; macs = 0;
      for (int cyc = 0; cyc < 200; cyc++) begin
        if (mac_clr4) macs = 0;
        if (mac_en4) macs++;
        if (wr_en4) begin
          chk($sformatf("wr_pos[%0d]", nwr), {row4, col4}, {3'(nwr / 4), 3'(nwr % 4)});
          chk("mac_per_elem", macs, 4);
          nwr++;
        end
        if (done4) begin
          ndone++;
          if (lat < 0) lat = cyc;
        end
`ifdef MATRIX_OP_CTRL_PERF_EN
        if (cyc == 99) chk("perf_dim4", cnt4, 98);
`endif
        start4 = (pass == 1) && (cyc == 10 || cyc == 50 || cyc == 90);
        tick();
      end
      start4 = 1'b0;
      chk("done_latency", lat, 97);
      chk("wr_count", nwr, 16);
      chk("done_count", ndone, 1);
    end

    // opclear on cycle 40
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    nwr = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (wr_en4) nwr++;
      tick();
    end
    clear4 = 1'b1;
    tick();
    clear4 = 1'b0;
    chk("abort_idle", act4, 0);
    ndone = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (wr_en4) nwr++;
      if (done4) ndone++;
      tick();
    end
    chk("abort_wr_count", nwr, 6);
    chk("abort_no_done", ndone, 0);

    // opstart during the DONE cycle is ignored; the next one starts an op
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int cyc = 0; cyc < 200 && !done4; cyc++) tick();
    chk("reached_done", done4, 1);
    start4 = 1'b1;
    tick();
    chk("start_in_done_ignored", state4, 0);
    tick();
    chk("start_after_done", state4, 1);
    start4 = 1'b0;
    clear4 = 1'b1;
    tick();
    clear4 = 1'b0;

    // Asynchronous reset mid-MAC
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int cyc = 0; cyc < 20 && state4 != 3'd3; cyc++) tick();
    chk("in_mac", state4, 3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_dut4", act4, 0);
    ndone = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      tick();
      if (done4 || busy4) ndone++;
    end
    chk("reset_holds_idle", ndone, 0);
    #2;
    reset_n = 1'b1;
    tick();
    chk("post_reset_idle", act4, 0);

`ifdef MATRIX_OP_CTRL_PERF_EN
    chk("perf_reset", {cnt4, cnt2}, 0);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int cyc = 0; cyc < 40 && !done2; cyc++) tick();
    tick();
    chk("perf_dim2", cnt2, 18);
    for (int cyc = 0; cyc < 5; cyc++) tick();
    chk("perf_hold", cnt2, 18);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("perf_clear_on_load", cnt2, 0);
    for (int cyc = 0; cyc < 5; cyc++) tick();
    chk("perf_counting", cnt2, 5);
    clear2 = 1'b1;
    tick();
    clear2 = 1'b0;
    tick();
    chk("perf_freeze", cnt2, 5);
`endif

    // Randomised run on both instances against the model
    clear4 = 1'b1;
    clear2 = 1'b1;
    tick();
    clear4 = 1'b0;
    clear2 = 1'b0;
    n4 = 0;
    n2 = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      s4 = ($urandom_range(0, 7) == 0);
      c4 = ($urandom_range(0, 79) == 0);
      s2 = ($urandom_range(0, 3) == 0);
      c2 = ($urandom_range(0, 29) == 0);
      start4 = s4; clear4 = c4; start2 = s2; clear2 = c2;
      nn4 = model_next(4, n4, s4, c4);
      nn2 = model_next(2, n2, s2, c2);
      tick();
      n4 = nn4;
      n2 = nn2;
      chk($sformatf("rand4[%0d]", cyc), act4, model(4, n4));
      chk($sformatf("rand2[%0d]", cyc), act2, model(2, n2));
    end
    start4 = 1'b0; clear4 = 1'b0; start2 = 1'b0; clear2 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
